ulpi_link_sched: RTL

Link-side ULPI bus scheduler between the PHY pins and the USB device core. Owns the single ULPI output bus, arbitrating a packet transmit stream and a PHY register access port, and generating the TX CMD, NXT handshake, STP and turnaround sequencing for both. Aborts and retries transactions the PHY pre-empts by asserting DIR. Optionally runs a PHY init register sequence after reset.

---
 rtl/ulpi_pkg.sv | 52 +++++
 rtl/ulpi_link_sched_if.sv | 60 ++++++
 rtl/ulpi_init_seq.sv | 60 ++++++
 rtl/ulpi_link_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// ulpi_pkg
//   Shared types and constants for the ULPI link scheduler:
//   - state_t       : scheduler FSM states
//   - CMD_*         : TX CMD prefixes driven on the ULPI bus
//   - NXT_TIMEOUT   : cycles a register TX CMD waits for NXT
//   - REG_*         : PHY register addresses used by the init sequence
//   - init_entry()  : init table lookup (address/data pair per index)
package ulpi_pkg;

  typedef enum logic [3:0] {
    IDLE,
    TX_CMD,
    TX_DATA,
    TX_STP,
    RG_CMD,
    RG_WDATA,
    RG_STP,
    RG_TURN,
    RG_RDATA,
    RG_END
  } state_t;

  localparam logic [7:0] NXT_TIMEOUT = 8'd255;

  localparam logic [7:0] CMD_TX   = 8'h40;
  localparam logic [7:0] CMD_REGW = 8'h80;
  localparam logic [7:0] CMD_REGR = 8'hC0;

  localparam logic [5:0] REG_FUNC_CTRL = 6'h04;
  localparam logic [5:0] REG_OTG_CTRL  = 6'h0A;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } init_entry_t;

  localparam int INIT_LEN = 2;

  // Init table: Function Control (FS transceiver + SuspendM), then OTG Control.
  function automatic init_entry_t init_entry(input logic idx);
    init_entry_t e;
    if (idx == 1'b0) begin
      e.addr = REG_FUNC_CTRL;
      e.data = 8'h41;
    end else begin
      e.addr = REG_OTG_CTRL;
      e.data = 8'h00;
    end
    return e;
  endfunction

endpackage

// File: rtl/ulpi_link_sched_if.sv
// ulpi_link_sched_if
//   Bundles the ULPI pins, the packet stream port, the register access port
//   and the FSM debug state of ulpi_link_sched.
//   modport slave  : the scheduler itself
//   modport master : the environment (PHY pins + USB device core)
//
// Handshake semantics:
//   tx stream : a byte transfers on a clock edge where tx_valid_i and
//               tx_ready_o are both high; tx_data_i/tx_last_i must stay
//               stable while tx_valid_i is high and tx_ready_o is low.
//   reg port  : reg_req_i and its we/addr/wdata are held stable until the
//               cycle reg_ack_o pulses; the requester may drop or change
//               them on the edge that ends the ack cycle.
interface ulpi_link_sched_if;
  import ulpi_pkg::*;

  logic [7:0] ulpi_data_out_i;
  logic       ulpi_dir_i;
  logic       ulpi_nxt_i;
  logic [7:0] ulpi_data_in_o;
  logic       ulpi_stp_o;

  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] tx_data_i;
  logic       tx_last_i;
  logic       tx_err_o;

  logic       reg_req_i;
  logic       reg_we_i;
  logic [5:0] reg_addr_i;
  logic [7:0] reg_wdata_i;
  logic       reg_ack_o;
  logic       reg_err_o;
  logic [7:0] reg_rdata_o;

  logic       init_done_o;
  state_t     dbg_state;

  modport slave (
    input  ulpi_data_out_i, ulpi_dir_i, ulpi_nxt_i,
    input  tx_valid_i, tx_data_i, tx_last_i,
    input  reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i,
    output ulpi_data_in_o, ulpi_stp_o,
    output tx_ready_o, tx_err_o,
    output reg_ack_o, reg_err_o, reg_rdata_o,
    output init_done_o, dbg_state
  );

  modport master (
    output ulpi_data_out_i, ulpi_dir_i, ulpi_nxt_i,
    output tx_valid_i, tx_data_i, tx_last_i,
    output reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i,
    input  ulpi_data_in_o, ulpi_stp_o,
    input  tx_ready_o, tx_err_o,
    input  reg_ack_o, reg_err_o, reg_rdata_o,
    input  init_done_o, dbg_state
  );

endinterface

// File: rtl/ulpi_init_seq.sv
// ulpi_init_seq
//   PHY init register sequencer (built only with ULPI_INIT_SEQ_EN defined).
//   Until both init writes have been acked without error it owns the
//   scheduler's internal register port; afterwards it passes the external
//   register port straight through.
//   Ports:
//     clk_i, rst_i            clock, async active-high reset
//     ext_*                   external register request (from device core)
//     core_ack/core_err       completion from the scheduler FSM
//     port_*                  muxed request into the scheduler FSM
//     ext_ack/ext_err         completion back to the device core
//     init_done               high once the init table is written
`ifdef ULPI_INIT_SEQ_EN
module ulpi_init_seq
  import ulpi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ext_req,
  input  logic       ext_we,
  input  logic [5:0] ext_addr,
  input  logic [7:0] ext_wdata,
  input  logic       core_ack,
  input  logic       core_err,
  output logic       port_req,
  output logic       port_we,
  output logic [5:0] port_addr,
  output logic [7:0] port_wdata,
  output logic       ext_ack,
  output logic       ext_err,
  output logic       init_done
);

  logic        idx_q;
  logic        done_q;
  init_entry_t ent;

  assign ent = init_entry(idx_q);

  // A timed-out write leaves idx_q unchanged, so the same entry is retried.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (!done_q && core_ack && !core_err) begin
      if (idx_q == 1'(INIT_LEN - 1)) done_q <= 1'b1;
      else                           idx_q  <= idx_q + 1'b1;
    end
  end

  assign port_req   = done_q ? ext_req   : 1'b1;
  assign port_we    = done_q ? ext_we    : 1'b1;
  assign port_addr  = done_q ? ext_addr  : ent.addr;
  assign port_wdata = done_q ? ext_wdata : ent.data;
  assign ext_ack    = done_q & core_ack;
  assign ext_err    = done_q & core_err;
  assign init_done  = done_q;

endmodule
`endif

// File: rtl/ulpi_link_sched.sv
// ulpi_link_sched
//   Link-side ULPI bus scheduler. Owns the ULPI output bus and arbitrates
//   between a packet transmit stream and a PHY register access port,
//   generating TX CMD, NXT handshake, STP and turnaround sequencing.
//   Transactions pre-empted by DIR are dropped and re-arbitrated.
//   Optional PHY init sequence: define ULPI_INIT_SEQ_EN.
//   Ports:
//     clk_i  60 MHz ULPI clock
//     rst_i  asynchronous active-high reset
//     bus    ulpi_link_sched_if.slave (ULPI pins, tx stream, reg port,
//            init_done_o, dbg_state)
module ulpi_link_sched
  import ulpi_pkg::*;
(
  input logic              clk_i,
  input logic              rst_i,
  ulpi_link_sched_if.slave bus
);

  state_t     state_q;
  logic [7:0] tmo_cnt_q;
  logic       last_reg_q;
  logic       ack_q;
  logic       err_q;
  logic       tx_err_q;
  logic [7:0] rdata_q;

  logic       port_req;
  logic       port_we;
  logic [5:0] port_addr;
  logic [7:0] port_wdata;
  logic       init_done;

  logic       dir;
  logic       nxt;
  logic       reg_go;
  logic       tx_go;

  assign dir = bus.ulpi_dir_i;
  assign nxt = bus.ulpi_nxt_i;

`ifdef ULPI_INIT_SEQ_EN
  ulpi_init_seq u_init_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ext_req    (bus.reg_req_i),
    .ext_we     (bus.reg_we_i),
    .ext_addr   (bus.reg_addr_i),
    .ext_wdata  (bus.reg_wdata_i),
    .core_ack   (ack_q),
    .core_err   (err_q),
    .port_req   (port_req),
    .port_we    (port_we),
    .port_addr  (port_addr),
    .port_wdata (port_wdata),
    .ext_ack    (bus.reg_ack_o),
    .ext_err    (bus.reg_err_o),
    .init_done  (init_done)
  );
`else
  assign port_req      = bus.reg_req_i;
  assign port_we       = bus.reg_we_i;
  assign port_addr     = bus.reg_addr_i;
  assign port_wdata    = bus.reg_wdata_i;
  assign bus.reg_ack_o = ack_q;
  assign bus.reg_err_o = err_q;
  assign init_done     = 1'b1;
`endif

  // Read and timeout acks land in IDLE while the requester still holds
  // reg_req_i; masking with ack_q stops that stale request being re-granted.
  assign reg_go = port_req & ~ack_q;
  assign tx_go  = bus.tx_valid_i & init_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tmo_cnt_q  <= '0;
      last_reg_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      tx_err_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      tx_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!dir) begin
            // Round robin: on contention grant whichever did not go last.
            if (reg_go && (!tx_go || !last_reg_q)) begin
              state_q    <= RG_CMD;
              last_reg_q <= 1'b1;
              tmo_cnt_q  <= '0;
            end else if (tx_go) begin
              state_q    <= TX_CMD;
              last_reg_q <= 1'b0;
            end
          end
        end
        TX_CMD: begin
          if (dir) state_q <= IDLE;
          else if (nxt && bus.tx_valid_i) state_q <= bus.tx_last_i ? TX_STP : TX_DATA;
        end
        TX_DATA: begin
          if (dir) begin
            state_q  <= IDLE;
            tx_err_q <= 1'b1;
          end else if (nxt) begin
            if (!bus.tx_valid_i) begin
              state_q  <= IDLE;
              tx_err_q <= 1'b1;
            end else if (bus.tx_last_i) begin
              state_q <= TX_STP;
            end
          end
        end
        TX_STP: state_q <= IDLE;
        RG_CMD: begin
          if (dir) begin
            state_q <= IDLE;
          end else if (nxt) begin
            state_q <= port_we ? RG_WDATA : RG_TURN;
          end else if (tmo_cnt_q == NXT_TIMEOUT - 8'd1) begin
            state_q <= IDLE;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        RG_WDATA: begin
          if (dir) begin
            state_q <= IDLE;
          end else if (nxt) begin
            state_q <= RG_STP;
            ack_q   <= 1'b1;
          end
        end
        RG_STP: state_q <= IDLE;
        RG_TURN: begin
          if (dir) state_q <= RG_RDATA;
        end
        RG_RDATA: begin
          rdata_q <= bus.ulpi_data_out_i;
          state_q <= RG_END;
        end
        RG_END: begin
          if (!dir) begin
            state_q <= IDLE;
            ack_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus outputs follow state, nxt and dir combinationally; with dir high the
  // PHY owns the bus and everything is held quiet.
  always_comb begin
    bus.ulpi_data_in_o = 8'h00;
    bus.ulpi_stp_o     = 1'b0;
    bus.tx_ready_o     = 1'b0;
    if (!dir) begin
      case (state_q)
        TX_CMD: begin
          bus.ulpi_data_in_o = CMD_TX | {4'h0, bus.tx_data_i[3:0]};
          bus.tx_ready_o     = nxt;
        end
        TX_DATA: begin
          bus.tx_ready_o = nxt;
          if (nxt && !bus.tx_valid_i) begin
            bus.ulpi_data_in_o = 8'hFF;
            bus.ulpi_stp_o     = 1'b1;
          end else begin
            bus.ulpi_data_in_o = bus.tx_data_i;
          end
        end
        TX_STP, RG_STP: bus.ulpi_stp_o = 1'b1;
        RG_CMD: bus.ulpi_data_in_o = (port_we ? CMD_REGW : CMD_REGR) | {2'b00, port_addr};
        RG_WDATA: bus.ulpi_data_in_o = port_wdata;
        default: ;
      endcase
    end
  end

  assign bus.tx_err_o    = tx_err_q;
  assign bus.reg_rdata_o = rdata_q;
  assign bus.init_done_o = init_done;
  assign bus.dbg_state   = state_q;

endmodule
